// File: rtl/me_pkg.sv
// ============================================================================
// Module : me_pkg
// Purpose: Shared constants and types for the modular-exponentiation core
//          and its result unloader: result width, output word width, tag
//          width, derived words-per-result and word index width, plus the
//          stream state encoding used by the unloader.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package me_pkg;

  localparam int M_SIZE = 3072;  // result width in bits
  localparam int RADIX  = 72;    // output word width in bits
  localparam int TAG_W  = 4;     // job tag width

  // Words needed to cover a result; the top word may be partially filled.
  function automatic int num_words(input int m_size, input int radix);
    return (m_size + radix - 1) / radix;
  endfunction

  localparam int NUM_WORDS = num_words(M_SIZE, RADIX);  // 43 for the defaults
  localparam int IDX_W     = 6;                         // holds 0..NUM_WORDS-1

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } stream_state_t;

endpackage

`default_nettype wire

// File: rtl/me_res_slot.sv
// ============================================================================
// Module : me_res_slot
// Purpose: One buffered result: M_SIZE data, TAG_W tag and a valid bit, with
//          a word-select mux that presents RADIX-bit word [idx] of the data.
//          The data is zero-extended to NUM_WORDS*RADIX bits so the top word
//          carries zeros above the result's MSB.
// Ports  : clk, rst_n        - clock, async active-low reset (valid only)
//          load              - capture data_in/tag_in, set valid (wins over clear)
//          clear             - drop valid
//          data_in, tag_in   - result and tag to capture
//          idx               - word index to present on word
//          word, tag, valid  - selected word, stored tag, occupancy
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module me_res_slot
  import me_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              clear,
  input  logic [M_SIZE-1:0] data_in,
  input  logic [TAG_W-1:0]  tag_in,
  input  logic [IDX_W-1:0]  idx,
  output logic [RADIX-1:0]  word,
  output logic [TAG_W-1:0]  tag,
  output logic              valid
);

  localparam int EXT_W = NUM_WORDS * RADIX;

  logic [M_SIZE-1:0] data_q;
  logic [EXT_W-1:0]  data_ext;
  logic [RADIX-1:0]  words [NUM_WORDS];

  // Payload needs no reset: it is only observed while valid is set.
  always_ff @(posedge clk) begin
    if (load) begin
      data_q <= data_in;
      tag    <= tag_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (clear) begin
      valid <= 1'b0;
    end
  end

  assign data_ext = EXT_W'(data_q);

  for (genvar k = 0; k < NUM_WORDS; k++) begin : g_word
    assign words[k] = data_ext[k*RADIX +: RADIX];
  end

  always_comb begin
    word = '0;
    if (int'(idx) < NUM_WORDS) begin
      word = words[idx];
    end
  end

endmodule

`default_nettype wire

// File: rtl/me_result_unloader.sv
// ============================================================================
// Module : me_result_unloader
// Purpose: Captures each result z / tag num_out from the exponentiation core
//          on done, buffers up to two results and streams each one out LS
//          word first over a valid/ready interface. A result arriving while
//          both slots are busy is dropped and sets the sticky overflow flag,
//          unless the final word of the current result is accepted in the
//          same cycle, in which case the freed slot is reused.
// Ports  : clk, rst_n                 - clock, async active-low reset
//          z, num_out, done           - result, tag, single-cycle strobe
//          out_data/tag/idx/last      - current word and its attributes
//          out_valid, out_ready       - stream handshake
//          busy, full, overflow       - buffer status
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module me_result_unloader
  import me_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [M_SIZE-1:0] z,
  input  logic [TAG_W-1:0]  num_out,
  input  logic              done,
  output logic [RADIX-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag,
  output logic [IDX_W-1:0]  out_idx,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              full,
  output logic              overflow
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);

  stream_state_t    state_q, state_d;
  logic             wp_q, rp_q;
  logic [1:0]       count_q, count_d;
  logic [IDX_W-1:0] idx_q;
  logic             overflow_q;

  logic             hs, final_hs, capture, drop;
  logic [1:0]       slot_load, slot_clear, slot_valid;
  logic [RADIX-1:0] slot_word [2];
  logic [TAG_W-1:0] slot_tag  [2];

  // When both slots are full, wp == rp, so a capture coinciding with the
  // final handshake lands in the slot being freed; load wins inside the slot.
  assign hs       = out_valid & out_ready;
  assign final_hs = hs & (idx_q == LAST_IDX);
  assign capture  = done & ((count_q != 2'd2) | final_hs);
  assign drop     = done & ~capture;

  for (genvar s = 0; s < 2; s++) begin : g_slot
    assign slot_load[s]  = capture  & (wp_q == (s != 0));
    assign slot_clear[s] = final_hs & (rp_q == (s != 0));

    me_res_slot u_slot (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (slot_load[s]),
      .clear   (slot_clear[s]),
      .data_in (z),
      .tag_in  (num_out),
      .idx     (idx_q),
      .word    (slot_word[s]),
      .tag     (slot_tag[s]),
      .valid   (slot_valid[s])
    );
  end

  // Stream FSM: SEND whenever at least one result is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    count_d = count_q;
    case ({capture, final_hs})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
    state_d = (count_d != 2'd0) ? ST_SEND : ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q       <= 1'b0;
      rp_q       <= 1'b0;
      count_q    <= 2'd0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      count_q <= count_d;
      if (capture) begin
        wp_q <= ~wp_q;
      end
      if (final_hs) begin
        rp_q  <= ~rp_q;
        idx_q <= '0;
      end else if (hs) begin
        idx_q <= idx_q + IDX_W'(1);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
    end
  end

  // Outputs depend only on flops; payload is forced to zero while idle.
  assign out_valid = (state_q == ST_SEND) & slot_valid[rp_q];
  assign out_data  = out_valid ? slot_word[rp_q] : '0;
  assign out_tag   = out_valid ? slot_tag[rp_q]  : '0;
  assign out_idx   = idx_q;
  assign out_last  = out_valid & (idx_q == LAST_IDX);
  assign busy      = (count_q != 2'd0);
  assign full      = (count_q == 2'd2);
  assign overflow  = overflow_q;

endmodule

`default_nettype wire

// File: doc/me_result_unloader.md
# me_result_unloader

Downstream stage of the modular-exponentiation core `me`. It captures each 3072-bit result `z` and its job tag `num_out` on the core's `done_top` pulse, and buffers up to two results. It streams each result out least-significant word first as RADIX-bit words over a valid/ready interface, so the core can finish a second job while the first is still draining.

## Interface
- M_SIZE, 3072, result width in bits
- RADIX, 72, output word width in bits
- TAG_W, 4, job tag width
- NUM_WORDS, ceil(M_SIZE/RADIX) = 43, words per result (derived, not overridable)
- IDX_W, 6, word index width, ≥ clog2(NUM_WORDS)
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- z  in  M_SIZE  result from `me`, valid in the cycle `done` is high
- num_out  in  TAG_W  job tag from `me`, valid with `done`
- done  in  1  single-cycle result strobe from `me` (`done_top`)
- out_data  out  RADIX  current output word
- out_tag  out  TAG_W  tag of the result being streamed
- out_idx  out  IDX_W  index of the current word, 0..NUM_WORDS-1
- out_last  out  1  high on word NUM_WORDS-1
- out_valid  out  1  word available
- out_ready  in  1  sink accepts word
- busy  out  1  at least one result buffered or streaming
- full  out  1  both slots occupied
- overflow  out  1  sticky: a result was dropped

## Operation
- Two result slots, each holding M_SIZE data, TAG_W tag and a valid bit.
  - Write pointer `wp`, read pointer `rp`, both 1 bit; `count` is 0..2.
- Capture: `done`=1 and `count`<2 → slot[wp] ← {z, num_out}; wp toggles; count+1.
- Drop: `done`=1 and `count`==2, with no final handshake in the same cycle.
  - The result is discarded and `overflow` ← 1.
  - `overflow` is cleared only by reset.
- Stream states:
  - IDLE: count==0, out_valid=0.
  - SEND: out_valid=1 and out_data = word[idx] of slot[rp].
- Handshake = out_valid & out_ready in the same cycle.
  - Each handshake increments idx.
  - The handshake at idx==NUM_WORDS-1 (the final handshake) frees slot[rp]: rp toggles, idx←0, count−1.
  - After the final handshake the block goes to SEND if count after update >0, otherwise to IDLE.
- Word mapping: word k = slot.data[k*RADIX +: RADIX].
  - The top word is zero-extended: for the defaults, word 42 = {24'b0, z[3071:3024]}.
- Simultaneous `done` and final handshake with count==2: the freed slot is reused in the same cycle. The result is captured (not dropped), `overflow` unchanged, count stays 2.
- Simultaneous `done` and final handshake with count==1: count stays 1 and the new result becomes the next stream.
- out_data, out_tag, out_idx and out_last hold stable while out_valid=1 and out_ready=0.
- busy = (count!=0). full = (count==2).

## Timing
- Reset values:
  - out_valid=0, out_last=0, out_idx=0, out_tag=0, out_data=0, busy=0, full=0, overflow=0.
  - count=0, wp=rp=0; slot valid bits cleared.
- Reset mid-stream discards all buffered results immediately and asynchronously. Streaming resumes only on the next `done`.
- Latency: `done` at edge T → out_valid=1 with word 0 after edge T (visible in cycle T+1). All outputs are registered.
- Throughput: with out_ready held high, one word per cycle, so one result takes NUM_WORDS=43 cycles.
- Back-to-back results: word 0 of the next slot is presented in the cycle after the final handshake, with no bubble.
- `done` arriving while IDLE and in the same cycle as reset release is ignored if rst_n is still low at the edge.

## Structure
- Shared package `me_pkg`:
  - M_SIZE, RADIX, TAG_W.
  - NUM_WORDS as a constant function ceil(M_SIZE/RADIX), and IDX_W.
  - These are the values `me` and its testbench already use.
- One sub-module, `me_res_slot`: a single result register (data, tag, valid) with load/clear and a word-select mux on an idx input.
- The top level instantiates two slots and adds the pointers, count, stream FSM and overflow logic.

## Test plan
- Single result: done with z=3072'h1, num_out=3, out_ready=1.
  - Word 0 = 72'h1 then 42 zero words; out_tag=3 on every word; out_last only on idx 42.
  - out_valid falls the cycle after the final handshake; busy=0.
- Word mapping: z with bit 3071 and bit 72 set.
  - word 1 = 72'h1; word 42 = {24'b0, 48'h8000_0000_0000}; all other words 0.
- Backpressure: toggle out_ready every cycle.
  - out_data and out_idx stay stable when out_ready=0; exactly 43 handshakes; data is identical to the free-flowing run.
- Two queued plus overflow: done(tag 3), then done(tag 4) two cycles later, then done(tag 5) while full with out_ready=0.
  - Tag 5 is dropped and overflow=1.
  - Tag 3 then tag 4 stream with no bubble between them.
- Simultaneous: count==2 and done(tag 6) in the same cycle as the final handshake of tag 3.
  - Tag 6 is captured, overflow stays 0, and the order is 4 then 6.
- Reset mid-stream: assert rst_n=0 at idx 20.
  - All outputs go to their reset values immediately.
  - After a new done(tag 7), streaming starts at idx 0.
